sc_neuron_sequencer: RTL and testbench

Job-level controller for the stochastic-computing APC neuron datapath. It accepts one neuron evaluation job of binary input values, weights and bias, and converts them to stochastic bitstreams with on-chip LFSR number generators. It drives the neuron for exactly one full LFSR period, counts the ones on the neuron output, and returns the count through a valid/ready result port. It sits between the layer-level scheduler and one neuron instance, owning that neuron's clear and stream inputs.

---
 rtl/sc_pkg.sv | 55 +++++
 rtl/sc_lfsr.sv | 37 +++
 rtl/sc_neuron_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_sc_neuron_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing neuron sequencer.
package sc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } sc_state_e;

    // Widest supported value precision; helpers work on this width.
    localparam int W_MAX = 12;

    localparam logic [W_MAX-1:0] SEED_X_DEF = 12'h001;
    localparam logic [W_MAX-1:0] SEED_W_DEF = 12'h05A;

    // Feedback masks for maximal-length Fibonacci LFSRs (shift left, feedback
    // into bit 0). Unsupported widths return 0.
    function automatic logic [W_MAX-1:0] lfsr_taps(input int w);
        case (w)
            4:       lfsr_taps = 12'h00C;
            5:       lfsr_taps = 12'h014;
            6:       lfsr_taps = 12'h030;
            7:       lfsr_taps = 12'h060;
            8:       lfsr_taps = 12'h0B8;
            9:       lfsr_taps = 12'h110;
            10:      lfsr_taps = 12'h240;
            11:      lfsr_taps = 12'h500;
            12:      lfsr_taps = 12'h829;
            default: lfsr_taps = 12'h000;
        endcase
    endfunction

    // Rotate the low w bits of v left by s; upper bits of the result are 0.
    function automatic logic [W_MAX-1:0] rotl(input logic [W_MAX-1:0] v, input int w, input int s);
        logic [W_MAX-1:0] r;
        r = '0;
        for (int j = 0; j < W_MAX; j++) begin
            if (j < w) r[(j + s) % w] = v[j];
        end
        return r;
    endfunction

    // Reverse the bit order of the low w bits of v.
    function automatic logic [W_MAX-1:0] bitrev(input logic [W_MAX-1:0] v, input int w);
        logic [W_MAX-1:0] r;
        r = '0;
        for (int j = 0; j < W_MAX; j++) begin
            if (j < w) r[w - 1 - j] = v[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous seed load and advance enable.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] SEED = '1
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         fb;

    // Next state: reseeding takes priority over advancing.
    always_comb begin
        fb  = ^(q_q & TAPS);
        q_d = q_q;
        if (load)    q_d = SEED;
        else if (en) q_d = {q_q[W-2:0], fb};
    end

    // State register; reset parks the generator on its seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q_q <= SEED;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sc_neuron_sequencer.sv
// Job-level controller for one stochastic APC neuron: converts a job to
// bitstreams for one full LFSR period and counts ones on the neuron output.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a job; job_ready high
// S_CLEAR  | one-cycle neuron clear pulse, streams held low
// S_STREAM | L cycles of stochastic streams, LFSRs advancing
// S_DRAIN  | DLY cycles letting the last stream bits reach neu_dout
// S_DONE   | result held on res_count until res_ready
module sc_neuron_sequencer
    import sc_pkg::*;
#(
    parameter int           K      = 3,
    parameter int           N      = 2**K,
    parameter int           W      = 8,
    parameter int           DLY    = 1,
    parameter logic [W-1:0] SEED_X = W'(SEED_X_DEF),
    parameter logic [W-1:0] SEED_W = W'(SEED_W_DEF)
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           job_valid,
    output logic           job_ready,
    input  logic [N*W-1:0] job_x,
    input  logic [N*W-1:0] job_w,
    input  logic [W-1:0]   job_b,
    output logic           neu_clr,
    output logic [N-1:0]   neu_din,
    output logic [N-1:0]   neu_weight,
    output logic           neu_bias,
    input  logic           neu_dout,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_count,
    output logic           busy
);

    localparam logic [W-1:0] ONE        = W'(1);
    localparam logic [W-1:0] L_MAX      = '1;
    localparam logic [W-1:0] L_LAST     = L_MAX - ONE;
    localparam logic [W-1:0] DRAIN_LAST = W'(DLY - 1);

    if (W < 4 || W > 12) begin : g_bad_w
        $error("sc_neuron_sequencer: W must be within 4..12");
    end
    if (DLY < 1 || DLY > 4) begin : g_bad_dly
        $error("sc_neuron_sequencer: DLY must be within 1..4");
    end
    if (N != 2**K) begin : g_bad_n
        $error("sc_neuron_sequencer: N must equal 2**K");
    end
    if (SEED_X == '0 || SEED_W == '0 || SEED_X == SEED_W) begin : g_bad_seed
        $error("sc_neuron_sequencer: seeds must be nonzero and distinct");
    end

    sc_state_e      state_q, state_d;
    logic [W-1:0]   cyc_q,   cyc_d;
    logic [W-1:0]   cnt_q,   cnt_d;
    logic [DLY-1:0] sh_q,    sh_d;
    logic [N*W-1:0] x_q,     x_d;
    logic [N*W-1:0] w_q,     w_d;
    logic [W-1:0]   b_q,     b_d;

    logic           accept;
    logic           streaming;
    logic [W-1:0]   lfsr_x;
    logic [W-1:0]   lfsr_w;
    logic [N-1:0]   cmp_x;
    logic [N-1:0]   cmp_w;
    logic [W-1:0]   r_b;
    logic           cmp_b;

    assign accept    = job_valid && (state_q == S_IDLE);
    assign streaming = (state_q == S_STREAM);

    sc_lfsr #(.W(W), .SEED(SEED_X)) u_lfsr_x (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (streaming),
        .q     (lfsr_x)
    );

    sc_lfsr #(.W(W), .SEED(SEED_W)) u_lfsr_w (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (streaming),
        .q     (lfsr_w)
    );

    // Each lane sees its own rotation of the shared LFSR state; a rotation of a
    // nonzero state is still a nonzero state, so every lane gets exact counts.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] r_x;
        logic [W-1:0] r_w;
        assign r_x      = W'(rotl(W_MAX'(lfsr_x), W, i % W));
        assign r_w      = W'(rotl(W_MAX'(lfsr_w), W, i % W));
        assign cmp_x[i] = (r_x <= x_q[i*W +: W]);
        assign cmp_w[i] = (r_w <= w_q[i*W +: W]);
    end

    assign r_b   = W'(bitrev(W_MAX'(lfsr_w), W));
    assign cmp_b = (r_b <= b_q);

    // Next-state logic: job capture, phase timers, and the delayed ones count.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        w_d     = w_q;
        b_d     = b_q;
        sh_d    = DLY'({sh_q, streaming});

        if (sh_q[DLY-1] && neu_dout && (cnt_q != L_MAX)) cnt_d = cnt_q + ONE;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    state_d = S_CLEAR;
                    x_d     = job_x;
                    w_d     = job_w;
                    b_d     = job_b;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                cyc_d   = L_LAST;
            end
            S_STREAM: begin
                if (cyc_q == '0) begin
                    state_d = S_DRAIN;
                    cyc_d   = DRAIN_LAST;
                end else begin
                    cyc_d = cyc_q - ONE;
                end
            end
            S_DRAIN: begin
                if (cyc_q == '0) state_d = S_DONE;
                else             cyc_d   = cyc_q - ONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            x_q     <= '0;
            w_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            x_q     <= x_d;
            w_q     <= w_d;
            b_q     <= b_d;
        end
    end

    // Stream outputs are forced low outside the streaming window.
    always_comb begin
        neu_din    = '0;
        neu_weight = '0;
        neu_bias   = 1'b0;
        if (streaming) begin
            neu_din    = cmp_x;
            neu_weight = cmp_w;
            neu_bias   = cmp_b;
        end
    end

    assign job_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign neu_clr   = (state_q == S_CLEAR);
    assign res_valid = (state_q == S_DONE);
    assign res_count = cnt_q;

endmodule

// File: tb/tb_sc_neuron_sequencer.sv
// Self-checking bench for sc_neuron_sequencer: two instances (DLY=1 and DLY=4),
// each driving a neuron stub that returns neu_din[0] delayed by DLY cycles.
module tb_sc_neuron_sequencer;

    localparam int K = 3;
    localparam int N = 8;
    localparam int W = 8;
    localparam int L = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A: DLY = 1 ----------------
    logic           a_reset, a_job_valid, a_job_ready, a_neu_clr, a_neu_bias, a_neu_dout;
    logic           a_res_valid, a_res_ready, a_busy;
    logic [N*W-1:0] a_job_x, a_job_w;
    logic [W-1:0]   a_job_b, a_res_count;
    logic [N-1:0]   a_neu_din, a_neu_weight;
    logic           a_pipe = 1'b0;

    sc_neuron_sequencer #(.K(K), .W(W), .DLY(1)) dut_a (
        .clk        (clk),
        .reset      (a_reset),
        .job_valid  (a_job_valid),
        .job_ready  (a_job_ready),
        .job_x      (a_job_x),
        .job_w      (a_job_w),
        .job_b      (a_job_b),
        .neu_clr    (a_neu_clr),
        .neu_din    (a_neu_din),
        .neu_weight (a_neu_weight),
        .neu_bias   (a_neu_bias),
        .neu_dout   (a_neu_dout),
        .res_valid  (a_res_valid),
        .res_ready  (a_res_ready),
        .res_count  (a_res_count),
        .busy       (a_busy)
    );

    always @(posedge clk) a_pipe <= a_neu_din[0];
    assign a_neu_dout = a_pipe;

    // ---------------- instance B: DLY = 4 ----------------
    logic           b_reset, b_job_valid, b_job_ready, b_neu_clr, b_neu_bias, b_neu_dout;
    logic           b_res_valid, b_res_ready, b_busy;
    logic [N*W-1:0] b_job_x, b_job_w;
    logic [W-1:0]   b_job_b, b_res_count;
    logic [N-1:0]   b_neu_din, b_neu_weight;
    logic [3:0]     b_pipe = 4'h0;

    sc_neuron_sequencer #(.K(K), .W(W), .DLY(4)) dut_b (
        .clk        (clk),
        .reset      (b_reset),
        .job_valid  (b_job_valid),
        .job_ready  (b_job_ready),
        .job_x      (b_job_x),
        .job_w      (b_job_w),
        .job_b      (b_job_b),
        .neu_clr    (b_neu_clr),
        .neu_din    (b_neu_din),
        .neu_weight (b_neu_weight),
        .neu_bias   (b_neu_bias),
        .neu_dout   (b_neu_dout),
        .res_valid  (b_res_valid),
        .res_ready  (b_res_ready),
        .res_count  (b_res_count),
        .busy       (b_busy)
    );

    always @(posedge clk) b_pipe <= {b_pipe[2:0], b_neu_din[0]};
    assign b_neu_dout = b_pipe[3];

    // Observations of the last job run on instance A.
    int obs_lat, obs_cnt, obs_clr_cnt, obs_clr_first, obs_stray, obs_hold_bad, obs_bias;
    int obs_din[N];
    int obs_wt[N];
    bit obs_idle_after;

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, 255));
        return v;
    endfunction

    // Model: a stream for value v over one full period carries exactly v ones;
    // the stub feeds lane 0 back, so the count equals x lane 0.
    function automatic int ones_expected(input logic [W-1:0] v);
        return int'(v);
    endfunction

    // Offer one job to A, watch it through to the result, optionally stall the
    // result for 'hold' cycles, then consume it.
    task automatic run_job(input logic [N*W-1:0] x, input logic [N*W-1:0] w,
                           input logic [W-1:0] b, input int hold);
        int k;
        @(negedge clk);
        a_job_x = x; a_job_w = w; a_job_b = b; a_job_valid = 1'b1; a_res_ready = 1'b0;
        k = 0;
        while (!a_job_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        a_job_valid = 1'b0;
        a_job_x = rand_vec(); a_job_w = rand_vec(); a_job_b = W'($urandom_range(0, 255));
        obs_lat = -1; obs_clr_cnt = 0; obs_clr_first = -1; obs_stray = 0;
        obs_hold_bad = 0; obs_bias = 0;
        for (int i = 0; i < N; i++) begin obs_din[i] = 0; obs_wt[i] = 0; end
        k = 0;
        while (obs_lat < 0 && k < 1000) begin
            @(negedge clk);
            k++;
            if (a_neu_clr) begin
                obs_clr_cnt++;
                if (obs_clr_first < 0) obs_clr_first = k;
            end
            if (k >= 2 && k <= L + 1) begin
                for (int i = 0; i < N; i++) begin
                    if (a_neu_din[i])    obs_din[i]++;
                    if (a_neu_weight[i]) obs_wt[i]++;
                end
                if (a_neu_bias) obs_bias++;
            end else if (a_neu_din != '0 || a_neu_weight != '0 || a_neu_bias) begin
                obs_stray++;
            end
            if (a_res_valid) obs_lat = k - 1;
        end
        obs_cnt = int'(a_res_count);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!a_res_valid || int'(a_res_count) != obs_cnt || a_job_ready) obs_hold_bad++;
        end
        a_res_ready = 1'b1;
        @(negedge clk);
        a_res_ready = 1'b0;
        obs_idle_after = a_job_ready && !a_res_valid && !a_busy;
    endtask

    task automatic test_reset();
        a_reset = 1'b0; b_reset = 1'b0;
        a_job_valid = 1'b0; a_res_ready = 1'b0; a_job_x = '0; a_job_w = '0; a_job_b = '0;
        b_job_valid = 1'b0; b_res_ready = 1'b0; b_job_x = '0; b_job_w = '0; b_job_b = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_job_ready !== 1'b1) begin n_bad++; $display("FAIL reset_job_ready got %b want 1", a_job_ready); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", a_busy); end
        n_cmp++; if (a_res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", a_res_valid); end
        n_cmp++; if (a_res_count !== '0) begin n_bad++; $display("FAIL reset_res_count got %0d want 0", a_res_count); end
        n_cmp++; if ({a_neu_clr, a_neu_din, a_neu_weight, a_neu_bias} !== '0) begin
            n_bad++; $display("FAIL reset_neu_outputs got %h want 0", {a_neu_clr, a_neu_din, a_neu_weight, a_neu_bias});
        end
        n_cmp++; if (b_job_ready !== 1'b1 || b_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_b_idle got ready=%b busy=%b want 1/0", b_job_ready, b_busy);
        end
        a_reset = 1'b1; b_reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (a_job_ready !== 1'b1 || a_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_idle got ready=%b busy=%b want 1/0", a_job_ready, a_busy);
        end
    endtask

    task automatic test_basic();
        logic [N*W-1:0] x;
        logic [W-1:0]   vals[3];
        vals[0] = 8'd0; vals[1] = 8'd255; vals[2] = 8'd100;
        for (int t = 0; t < 3; t++) begin
            x = rand_vec();
            x[W-1:0] = vals[t];
            run_job(x, rand_vec(), W'($urandom_range(0, 255)), 0);
            n_cmp++; if (obs_lat != L + 2) begin
                n_bad++; $display("FAIL basic_latency x0=%0d got %0d want %0d", vals[t], obs_lat, L + 2);
            end
            n_cmp++; if (obs_cnt != ones_expected(vals[t])) begin
                n_bad++; $display("FAIL basic_count x0=%0d got %0d want %0d", vals[t], obs_cnt, ones_expected(vals[t]));
            end
            n_cmp++; if (!obs_idle_after) begin
                n_bad++; $display("FAIL basic_return_idle x0=%0d got busy want idle", vals[t]);
            end
        end
    endtask

    task automatic test_streams();
        logic [N*W-1:0] x, w;
        x = {N{8'd128}};
        w = {N{8'd255}};
        run_job(x, w, 8'd0, 0);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (obs_din[i] != 128) begin
                n_bad++; $display("FAIL streams_din lane %0d got %0d want 128", i, obs_din[i]);
            end
            n_cmp++; if (obs_wt[i] != 255) begin
                n_bad++; $display("FAIL streams_weight lane %0d got %0d want 255", i, obs_wt[i]);
            end
        end
        n_cmp++; if (obs_bias != 0) begin n_bad++; $display("FAIL streams_bias got %0d want 0", obs_bias); end
        n_cmp++; if (obs_clr_cnt != 1 || obs_clr_first != 1) begin
            n_bad++; $display("FAIL streams_clr got count=%0d first=%0d want 1/1", obs_clr_cnt, obs_clr_first);
        end
        n_cmp++; if (obs_stray != 0) begin n_bad++; $display("FAIL streams_outside got %0d want 0", obs_stray); end
        n_cmp++; if (obs_cnt != 128) begin n_bad++; $display("FAIL streams_count got %0d want 128", obs_cnt); end
    endtask

    task automatic test_random();
        logic [N*W-1:0] x, w;
        logic [W-1:0]   b;
        for (int t = 0; t < 3; t++) begin
            x = rand_vec(); w = rand_vec(); b = W'($urandom_range(0, 255));
            run_job(x, w, b, 0);
            for (int i = 0; i < N; i++) begin
                n_cmp++; if (obs_din[i] != ones_expected(x[i*W +: W])) begin
                    n_bad++; $display("FAIL random_din job %0d lane %0d got %0d want %0d", t, i, obs_din[i], ones_expected(x[i*W +: W]));
                end
                n_cmp++; if (obs_wt[i] != ones_expected(w[i*W +: W])) begin
                    n_bad++; $display("FAIL random_weight job %0d lane %0d got %0d want %0d", t, i, obs_wt[i], ones_expected(w[i*W +: W]));
                end
            end
            n_cmp++; if (obs_bias != ones_expected(b)) begin
                n_bad++; $display("FAIL random_bias job %0d got %0d want %0d", t, obs_bias, ones_expected(b));
            end
            n_cmp++; if (obs_cnt != ones_expected(x[W-1:0])) begin
                n_bad++; $display("FAIL random_count job %0d got %0d want %0d", t, obs_cnt, ones_expected(x[W-1:0]));
            end
            n_cmp++; if (obs_stray != 0 || obs_clr_cnt != 1) begin
                n_bad++; $display("FAIL random_outside job %0d got stray=%0d clr=%0d want 0/1", t, obs_stray, obs_clr_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] x;
        x = rand_vec();
        run_job(x, rand_vec(), W'($urandom_range(0, 255)), 20);
        n_cmp++; if (obs_hold_bad != 0) begin
            n_bad++; $display("FAIL backpressure_hold got %0d unstable cycles want 0", obs_hold_bad);
        end
        n_cmp++; if (obs_cnt != ones_expected(x[W-1:0])) begin
            n_bad++; $display("FAIL backpressure_count got %0d want %0d", obs_cnt, ones_expected(x[W-1:0]));
        end
        n_cmp++; if (!obs_idle_after) begin
            n_bad++; $display("FAIL backpressure_release got busy want idle");
        end
    endtask

    task automatic test_mid_reset();
        logic [N*W-1:0] x;
        x = rand_vec();
        x[W-1:0] = 8'd255;
        @(negedge clk);
        a_job_x = x; a_job_w = rand_vec(); a_job_b = W'($urandom_range(0, 255)); a_job_valid = 1'b1;
        @(posedge clk);
        #1 a_job_valid = 1'b0;
        // First negedge after accept is CLEAR; stream cycle 100 is the 101st.
        repeat (101) @(negedge clk);
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL midrst_inflight got busy=%b want 1", a_busy); end
        #2 a_reset = 1'b0;
        #1;
        n_cmp++; if (a_job_ready !== 1'b1 || a_busy !== 1'b0) begin
            n_bad++; $display("FAIL midrst_state got ready=%b busy=%b want 1/0", a_job_ready, a_busy);
        end
        n_cmp++; if (a_res_valid !== 1'b0 || a_res_count !== '0) begin
            n_bad++; $display("FAIL midrst_result got valid=%b count=%0d want 0/0", a_res_valid, a_res_count);
        end
        n_cmp++; if ({a_neu_clr, a_neu_din, a_neu_weight, a_neu_bias} !== '0) begin
            n_bad++; $display("FAIL midrst_streams got %h want 0", {a_neu_clr, a_neu_din, a_neu_weight, a_neu_bias});
        end
        @(negedge clk);
        a_reset = 1'b1;
        x = rand_vec();
        x[W-1:0] = 8'd42;
        run_job(x, rand_vec(), W'($urandom_range(0, 255)), 0);
        n_cmp++; if (obs_cnt != 42) begin n_bad++; $display("FAIL midrst_fresh_count got %0d want 42", obs_cnt); end
        n_cmp++; if (obs_lat != L + 2) begin n_bad++; $display("FAIL midrst_fresh_latency got %0d want %0d", obs_lat, L + 2); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int res_q[$];
        logic [W-1:0] xs[2];
        int cyc;
        xs[0] = W'($urandom_range(0, 255));
        xs[1] = W'($urandom_range(0, 255));
        cyc = 0;
        @(negedge clk);
        a_res_ready = 1'b1;
        a_job_valid = 1'b1;
        a_job_x = rand_vec(); a_job_x[W-1:0] = xs[0];
        while (res_q.size() < 2 && cyc < 1000) begin
            if (a_job_valid && a_job_ready) acc_cyc.push_back(cyc);
            if (a_res_valid && a_res_ready) res_q.push_back(int'(a_res_count));
            @(negedge clk);
            cyc++;
            if (acc_cyc.size() == 1) begin
                a_job_x = rand_vec(); a_job_x[W-1:0] = xs[1];
            end else if (acc_cyc.size() >= 2) begin
                a_job_valid = 1'b0;
            end
        end
        @(negedge clk);
        a_res_ready = 1'b0;
        a_job_valid = 1'b0;
        n_cmp++; if (acc_cyc.size() != 2 || res_q.size() != 2) begin
            n_bad++; $display("FAIL b2b_progress got accepts=%0d results=%0d want 2/2", acc_cyc.size(), res_q.size());
        end else begin
            n_cmp++; if (acc_cyc[1] - acc_cyc[0] != L + 1 + 3) begin
                n_bad++; $display("FAIL b2b_spacing got %0d want %0d", acc_cyc[1] - acc_cyc[0], L + 4);
            end
            n_cmp++; if (res_q[0] != ones_expected(xs[0])) begin
                n_bad++; $display("FAIL b2b_count0 got %0d want %0d", res_q[0], ones_expected(xs[0]));
            end
            n_cmp++; if (res_q[1] != ones_expected(xs[1])) begin
                n_bad++; $display("FAIL b2b_count1 got %0d want %0d", res_q[1], ones_expected(xs[1]));
            end
        end
    endtask

    task automatic test_dly4();
        logic [W-1:0] x0;
        int k, lat;
        for (int t = 0; t < 2; t++) begin
            x0 = (t == 0) ? 8'd200 : W'($urandom_range(0, 255));
            @(negedge clk);
            n_cmp++; if (b_job_ready !== 1'b1) begin n_bad++; $display("FAIL dly4_ready got %b want 1", b_job_ready); end
            b_job_x = rand_vec(); b_job_x[W-1:0] = x0; b_job_w = rand_vec();
            b_job_b = W'($urandom_range(0, 255)); b_job_valid = 1'b1;
            @(posedge clk);
            #1 b_job_valid = 1'b0;
            lat = -1; k = 0;
            while (lat < 0 && k < 1000) begin
                @(negedge clk);
                k++;
                if (b_res_valid) lat = k - 1;
            end
            n_cmp++; if (lat != L + 5) begin n_bad++; $display("FAIL dly4_latency x0=%0d got %0d want %0d", x0, lat, L + 5); end
            n_cmp++; if (int'(b_res_count) != ones_expected(x0)) begin
                n_bad++; $display("FAIL dly4_count got %0d want %0d", b_res_count, ones_expected(x0));
            end
            b_res_ready = 1'b1;
            @(negedge clk);
            b_res_ready = 1'b0;
            n_cmp++; if (b_job_ready !== 1'b1 || b_res_valid !== 1'b0) begin
                n_bad++; $display("FAIL dly4_return_idle got ready=%b valid=%b want 1/0", b_job_ready, b_res_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_streams();
        test_random();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_dly4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
